// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_unit
// Purpose  : Iterative radix-2 shift-add multiplier with HI/LO result registers
// Revision : 1.0
// ============================================================================
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_multE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mthiE,
    input  logic             mtloE,
    output logic             busy_multE,
    output logic             mult_doneE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [c_CW-1:0]    r_count;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_start;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_product;

    assign w_start   = (r_state == S_IDLE) && start_multE;
    assign w_mag_a   = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign w_mag_b   = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
    // Upper accumulator half plus multiplicand, carry kept in the extra bit
    assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_product = r_neg ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start_multE) w_next = S_RUN;
            S_RUN:    if (r_count == c_LAST) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == S_RUN) && (r_count == c_LAST);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                    end else begin
                        if (mthiE) r_hi <= srcaE;
                        if (mtloE) r_lo <= srcaE;
                    end
                end
                S_RUN: begin
                    // {carry, acc, multiplier} >> 1: acc LSB moves into multiplier MSB
                    r_acc    <= {w_add, r_acc[WIDTH-1:1]};
                    r_mplier <= {r_acc[0], r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + 1'b1;
                end
                S_FINISH: begin
                    r_hi <= w_product[2*WIDTH-1:WIDTH];
                    r_lo <= w_product[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy_multE = (r_state != S_IDLE);
    assign mult_doneE = r_done;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_unit
// Purpose  : Self-checking bench for mult_unit against an arithmetic model
// Revision : 1.0
// ============================================================================
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_multE;
    logic        signedE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        mthiE;
    logic        mtloE;
    logic        busy_multE;
    logic        mult_doneE;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_multE (start_multE),
        .signedE     (signedE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .mthiE       (mthiE),
        .mtloE       (mtloE),
        .busy_multE  (busy_multE),
        .mult_doneE  (mult_doneE),
        .hi          (hi),
        .lo          (lo)
    );

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // poke_kind: 0 none, 1 second start, 2 mtlo, 3 reset -- applied for one cycle at poke_cyc
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input int poke_cyc, input int poke_kind, input logic [31:0] pdata,
                            output int busy_cnt, output int done_cyc, output int done_cnt,
                            output logic [31:0] lo_first, output logic [31:0] lo_after_poke);
        int cyc;
        start_multE = 1'b1;
        srcaE = a;
        srcbE = b;
        signedE = s;
        tick();
        start_multE = 1'b0;
        mtloE = 1'b0;
        lo_first = lo;
        lo_after_poke = lo;
        cyc = 1;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        while (busy_multE && cyc < 100) begin
            busy_cnt++;
            if (mult_doneE) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == poke_cyc) begin
                case (poke_kind)
                    1: begin
                        start_multE = 1'b1;
                        srcaE = pdata;
                        srcbE = ~pdata;
                        signedE = ~s;
                    end
                    2: begin
                        mtloE = 1'b1;
                        srcaE = pdata;
                    end
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
            tick();
            if (cyc == poke_cyc) begin
                start_multE = 1'b0;
                mtloE = 1'b0;
                reset = 1'b0;
                lo_after_poke = lo;
            end
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_vec++;
        if (busy_multE !== 1'b0 || mult_doneE !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0",
                     busy_multE, mult_doneE, hi, lo);
        end
    endtask

    task automatic test_unsigned_small;
        int bc, dc, dn;
        logic [31:0] l1, lp;
        n_vec++;
        if (busy_multE !== 1'b0) begin
            n_err++;
            $display("FAIL small_cycle0_busy: got %b expected 0", busy_multE);
        end
        run_mult(32'd3, 32'd5, 1'b0, 0, 0, 32'h0, bc, dc, dn, l1, lp);
        n_vec++;
        if (bc != 33 || dc != 33 || dn != 1) begin
            n_err++;
            $display("FAIL small_timing: busy=%0d done_cyc=%0d pulses=%0d expected 33 33 1",
                     bc, dc, dn);
        end
        n_vec++;
        if (hi !== 32'h0 || lo !== 32'hF || mult_doneE !== 1'b0) begin
            n_err++;
            $display("FAIL small_result: hi=%h lo=%h done=%b expected 0 f 0", hi, lo, mult_doneE);
        end
    endtask

    task automatic test_directed;
        logic [31:0] av [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] bv [4] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'hFFFFFFFD};
        logic        sv [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] ex [4] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFF,
                                64'h40000000_00000000, 64'h00000000_00000015};
        int bc, dc, dn;
        logic [31:0] l1, lp;
        for (int i = 0; i < 4; i++) begin
            run_mult(av[i], bv[i], sv[i], 0, 0, 32'h0, bc, dc, dn, l1, lp);
            n_vec++;
            if ({hi, lo} !== ex[i] || bc != 33) begin
                n_err++;
                $display("FAIL directed_%0d: hi:lo=%h busy=%0d expected %h busy=33",
                         i, {hi, lo}, bc, ex[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic        s;
        logic [63:0] ex;
        int bc, dc, dn;
        logic [31:0] l1, lp;
        for (int i = 0; i < 24; i++) begin
            a = $urandom();
            b = $urandom();
            s = 1'($urandom_range(0, 1));
            if (i % 6 == 5) a = 32'h80000000;
            if (i % 8 == 7) b = 32'h0;
            ex = ref_mult(a, b, s);
            run_mult(a, b, s, 0, 0, 32'h0, bc, dc, dn, l1, lp);
            n_vec++;
            if ({hi, lo} !== ex || bc != 33 || dn != 1) begin
                n_err++;
                $display("FAIL random_%0d: a=%h b=%h s=%b got %h busy=%0d pulses=%0d expected %h",
                         i, a, b, s, {hi, lo}, bc, dn, ex);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int bc, dc, dn;
        logic [31:0] l1, lp;
        run_mult(32'd1234567, 32'hFFFF0001, 1'b1, 10, 1, 32'h0BADF00D, bc, dc, dn, l1, lp);
        n_vec++;
        if ({hi, lo} !== ref_mult(32'd1234567, 32'hFFFF0001, 1'b1) || bc != 33) begin
            n_err++;
            $display("FAIL start_while_busy: got %h busy=%0d expected %h busy=33",
                     {hi, lo}, bc, ref_mult(32'd1234567, 32'hFFFF0001, 1'b1));
        end
        n_vec++;
        if (busy_multE !== 1'b0) begin
            n_err++;
            $display("FAIL start_while_busy_idle: busy=%b expected 0", busy_multE);
        end
    endtask

    task automatic test_back_to_back;
        int bc, dc, dn;
        logic [31:0] l1, lp;
        run_mult(32'd100, 32'd200, 1'b0, 0, 0, 32'h0, bc, dc, dn, l1, lp);
        run_mult(32'hFFFFFFFE, 32'd9, 1'b1, 0, 0, 32'h0, bc, dc, dn, l1, lp);
        n_vec++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEE || bc != 33 || dc != 33) begin
            n_err++;
            $display("FAIL back_to_back: got %h busy=%0d done_cyc=%0d expected ffffffffffffffee 33 33",
                     {hi, lo}, bc, dc);
        end
    endtask

    task automatic test_reset_mid_run;
        int bc, dc, dn;
        int late;
        logic [31:0] l1, lp;
        n_vec++;
        if ({hi, lo} === 64'h0) begin
            n_err++;
            $display("FAIL reset_mid_precond: hi:lo=%h expected nonzero", {hi, lo});
        end
        run_mult(32'h00ABCDEF, 32'h00012345, 1'b0, 10, 3, 32'h0, bc, dc, dn, l1, lp);
        n_vec++;
        if (busy_multE !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || bc != 10) begin
            n_err++;
            $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h busy_cycles=%0d expected 0 0 0 10",
                     busy_multE, hi, lo, bc);
        end
        late = 0;
        for (int i = 0; i < 40; i++) begin
            if (mult_doneE || busy_multE || hi != 0 || lo != 0) late++;
            tick();
        end
        n_vec++;
        if (late != 0) begin
            n_err++;
            $display("FAIL reset_mid_aftermath: %0d cycles with activity expected 0", late);
        end
    endtask

    task automatic test_mthi_mtlo;
        int bc, dc, dn;
        logic [31:0] l1, lp;
        mtloE = 1'b1;
        srcaE = 32'hCAFEBABE;
        tick();
        mtloE = 1'b0;
        mthiE = 1'b1;
        srcaE = 32'h12345678;
        tick();
        mthiE = 1'b0;
        n_vec++;
        if (hi !== 32'h12345678 || lo !== 32'hCAFEBABE) begin
            n_err++;
            $display("FAIL mthi_idle: hi=%h lo=%h expected 12345678 cafebabe", hi, lo);
        end
        mthiE = 1'b1;
        mtloE = 1'b1;
        srcaE = 32'h5A5A0F0F;
        tick();
        mthiE = 1'b0;
        mtloE = 1'b0;
        n_vec++;
        if (hi !== 32'h5A5A0F0F || lo !== 32'h5A5A0F0F) begin
            n_err++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h expected 5a5a0f0f 5a5a0f0f", hi, lo);
        end
        run_mult(32'd6, 32'd7, 1'b0, 12, 2, 32'hDEADBEEF, bc, dc, dn, l1, lp);
        n_vec++;
        if (lp !== 32'h5A5A0F0F || lo !== 32'd42 || hi !== 32'h0) begin
            n_err++;
            $display("FAIL mtlo_during_run: lo_after=%h final=%h:%h expected 5a5a0f0f 0:2a",
                     lp, hi, lo);
        end
        mtloE = 1'b1;
        run_mult(32'hFFFFFFFB, 32'd3, 1'b1, 0, 0, 32'h0, bc, dc, dn, l1, lp);
        n_vec++;
        if (l1 !== 32'd42 || {hi, lo} !== 64'hFFFFFFFF_FFFFFFF1 || bc != 33) begin
            n_err++;
            $display("FAIL mtlo_with_start: lo_c1=%h final=%h busy=%0d expected 2a fffffffffffffff1 33",
                     l1, {hi, lo}, bc);
        end
    endtask

    initial begin
        reset = 1'b0;
        start_multE = 1'b0;
        signedE = 1'b0;
        srcaE = '0;
        srcbE = '0;
        mthiE = 1'b0;
        mtloE = 1'b0;
        tick();
        test_reset();
        test_unsigned_small();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_mthi_mtlo();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_unit.md
# mult_unit

Iterative 32×32 multiplier with HI/LO registers for the Execute stage. It accepts a multiply on `start_multE`, runs a radix-2 shift-add sequence, and holds `busy_multE` high until the 64-bit product is committed to HI/LO. The hazard detector uses `start_multE | busy_multE` to stall Fetch and Decode and flush Execute. HI/LO feed the mfhi/mflo result path, and the unit also services mthi/mtlo writes.

## Interface
- `WIDTH`, default 32: operand width; the product is 2×WIDTH bits.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start_multE`  in  1  a mult/multu is in Execute; sampled only in IDLE.
- `signedE`  in  1  1 = mult (two's complement), 0 = multu.
- `srcaE`  in  WIDTH  multiplicand; also the mthi/mtlo data.
- `srcbE`  in  WIDTH  multiplier.
- `mthiE`  in  1  write `srcaE` to HI.
- `mtloE`  in  1  write `srcaE` to LO.
- `busy_multE`  out  1  a multiply is in progress.
- `mult_doneE`  out  1  one-cycle pulse on the cycle HI/LO become valid.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- The clock is `clk` and the reset is `reset`: synchronous, active-high. There is one clock domain.
- States are IDLE, RUN and FINISH. `busy_multE` is 1 in RUN and FINISH, and 0 in IDLE.
- **IDLE, when `start_multE` = 1:**
  - latch the multiplicand magnitude `|srcaE|` and the multiplier magnitude `|srcbE|`;
  - magnitudes apply only when `signedE` = 1; otherwise the raw values are latched;
  - latch `neg = signedE & (srcaE[31] ^ srcbE[31])`;
  - clear the 64-bit accumulator;
  - set count = 0 and go to RUN.
- Magnitude of 0x80000000 is 0x80000000, held as an unsigned 32-bit value; no overflow.
- **RUN, one iteration per cycle:**
  - if multiplier bit 0 is 1, add the multiplicand to accumulator[63:32], keeping the carry;
  - then shift {carry, accumulator, multiplier} right by 1;
  - after count = 31 (32 iterations), go to FINISH.
- **FINISH:**
  - product = neg ? two's-complement negate of the accumulator : accumulator;
  - at the clock edge, write `hi` = product[63:32] and `lo` = product[31:0];
  - pulse `mult_doneE` and go to IDLE.
- `start_multE` is ignored in RUN and FINISH. Operands are taken only from the IDLE cycle.
- **mthi/mtlo:**
  - honoured only in IDLE with `start_multE` = 0;
  - `hi`/`lo` take `srcaE` at the edge;
  - if both are asserted, both registers are written;
  - ignored while busy or when a start is asserted in the same cycle (start wins).
- HI/LO hold their value at all other times. During RUN the previous HI/LO stay readable.

## Timing
- **Reset values:** state = IDLE, `busy_multE` = 0, `mult_doneE` = 0, `hi` = 0, `lo` = 0, count = 0.
- Reset in any state, including mid-RUN, aborts the multiply. The unit enters IDLE and clears HI/LO on the next edge; no partial result is written.
- **Latency:**
  - start sampled in cycle 0;
  - RUN in cycles 1–32;
  - FINISH in cycle 33;
  - `busy_multE` = 1 in cycles 1–33;
  - `mult_doneE` = 1 in cycle 33;
  - new `hi`/`lo` are visible from cycle 34, when `busy_multE` = 0.
- A back-to-back start is accepted in cycle 34 at the earliest, from IDLE.
- The stall window is covered continuously:
  - cycle 0 by `start_multE`;
  - cycles 1–33 by `busy_multE`;
  - an mfhi/mflo held in Decode therefore reads the committed result.
- There are no combinational paths from inputs to outputs. All outputs are registered, except `busy_multE`, which is decoded from the state register.

## Test plan
- Unsigned 3 × 5: `srcaE` = 3, `srcbE` = 5, `signedE` = 0, start for 1 cycle. Required:
  - `busy_multE` high for exactly 33 cycles;
  - `mult_doneE` in cycle 33;
  - `hi` = 0x00000000 and `lo` = 0x0000000F in cycle 34.
- Unsigned max: 0xFFFFFFFF × 0xFFFFFFFF, `signedE` = 0 -> `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- Signed cases, `signedE` = 1:
  - -1 × 1 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFF;
  - 0x80000000 × 0x80000000 -> `hi` = 0x40000000, `lo` = 0x00000000;
  - -7 × -3 -> `hi` = 0, `lo` = 21.
- Start while busy: a second start with different operands in cycle 10 is ignored. The result matches the first operands, and busy stays 33 cycles total.
- Reset mid-operation: assert `reset` in cycle 10 of a RUN. Required: `busy_multE` = 0, `hi` = `lo` = 0 from the next cycle, and no `mult_doneE` pulse afterwards.
- mthi/mtlo:
  - in IDLE, `mthiE` with `srcaE` = 0x12345678 -> `hi` = 0x12345678, `lo` unchanged;
  - `mtloE` during RUN -> no change to `lo`;
  - `mtloE` together with `start_multE` -> the multiply starts and `lo` is not written directly.
